// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_ctrl_pkg : state encoding and default widths for mem_access_ctrl  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package mem_ctrl_pkg;

  localparam int c_ADDR_W = 4;
  localparam int c_DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR   = 3'd1,
    ST_RD1  = 3'd2,
    ST_RD2  = 3'd3,
    ST_RSP  = 3'd4,
    ST_VF1  = 3'd5,
    ST_VF2  = 3'd6
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_access_ctrl : valid/ready request front-end for a 2-cycle-read    |
// | single-port memory. Optional write-verify: MEMCTRL_WRVERIFY_EN.       |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = c_ADDR_W,
  parameter int DATA_W = c_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_wr,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_wdata,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DATA_W-1:0] o_rsp_data,
  output logic              o_wr_err,
  output logic              o_mem_cs,
  output logic              o_mem_en,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_din,
  input  logic [DATA_W-1:0] i_mem_q
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_req_ready;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_data;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                w_accept;
  logic                w_mem_cs;
  logic                w_mem_en;

  // req_ready is only ever high in IDLE, so an accept implies IDLE
  assign w_accept = i_req_valid && r_req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_mem_cs    = 1'b0;
    w_mem_en    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = i_req_wr ? ST_WR : ST_RD1;
        end
      end
      ST_WR: begin
        w_mem_cs = 1'b1;
        w_mem_en = 1'b1;
`ifdef MEMCTRL_WRVERIFY_EN
        w_state_nxt = ST_VF1;
`else
        w_state_nxt = ST_IDLE;
`endif
      end
      ST_RD1: begin
        w_mem_cs    = 1'b1;
        w_state_nxt = ST_RD2;
      end
      ST_RD2: begin
        w_mem_cs    = 1'b1;
        w_state_nxt = ST_RSP;
      end
      ST_RSP: begin
        if (r_rsp_valid && i_rsp_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
`ifdef MEMCTRL_WRVERIFY_EN
      ST_VF1: begin
        w_mem_cs    = 1'b1;
        w_state_nxt = ST_VF2;
      end
      ST_VF2: begin
        w_mem_cs    = 1'b1;
        w_state_nxt = ST_IDLE;
      end
`endif
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
    end else begin
      r_req_ready <= (w_state_nxt == ST_IDLE);
      if (w_accept) begin
        r_addr  <= i_req_addr;
        r_wdata <= i_req_wdata;
      end
      // mem_q is valid in RD2 because cs stays high with en low
      if (r_state == ST_RD2) begin
        r_rsp_data  <= i_mem_q;
        r_rsp_valid <= 1'b1;
      end else if (r_state == ST_RSP && i_rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

`ifdef MEMCTRL_WRVERIFY_EN
  logic r_wr_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_err <= 1'b0;
    end else if (r_state == ST_VF2 && i_mem_q != r_wdata) begin
      r_wr_err <= 1'b1;
    end
  end

  assign o_wr_err = r_wr_err;
`else
  assign o_wr_err = 1'b0;
`endif

  assign o_req_ready = r_req_ready;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_data  = r_rsp_data;
  assign o_mem_cs    = w_mem_cs;
  assign o_mem_en    = w_mem_en;
  assign o_mem_addr  = r_addr;
  assign o_mem_din   = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mem_access_ctrl : directed self-checking bench with a 16x8 memory  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_mem_access_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_wr = 1'b0;
  logic [3:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_data;
  logic       wr_err;
  logic       mem_cs;
  logic       mem_en;
  logic [3:0] mem_addr;
  logic [7:0] mem_din;
  logic [7:0] mem_q;

  logic [7:0] mem_array [16];
  logic [7:0] mem_qreg = '0;
  logic       force_q0 = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Single-port memory: writes when cs&en, loads output register when cs&!en
  always @(posedge clk) begin
    if (mem_cs) begin
      if (mem_en) mem_array[mem_addr] <= mem_din;
      else        mem_qreg <= mem_array[mem_addr];
    end
  end
  assign mem_q = force_q0 ? 8'h00 : mem_qreg;

  mem_access_ctrl #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_wr    (req_wr),
    .i_req_addr  (req_addr),
    .i_req_wdata (req_wdata),
    .o_rsp_valid (rsp_valid),
    .i_rsp_ready (rsp_ready),
    .o_rsp_data  (rsp_data),
    .o_wr_err    (wr_err),
    .o_mem_cs    (mem_cs),
    .o_mem_en    (mem_en),
    .o_mem_addr  (mem_addr),
    .o_mem_din   (mem_din),
    .i_mem_q     (mem_q)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (req_ready !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    chk("ready_wait", {31'd0, req_ready}, 32'd1);
  endtask

  task automatic do_write(input logic [3:0] a, input logic [7:0] d, input bit corrupt);
    wait_ready();
    req_valid = 1'b1; req_wr = 1'b1; req_addr = a; req_wdata = d;
    tick();
    req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
    chk("wr_cs",    {31'd0, mem_cs},    32'd1);
    chk("wr_en",    {31'd0, mem_en},    32'd1);
    chk("wr_addr",  {28'd0, mem_addr},  {28'd0, a});
    chk("wr_din",   {24'd0, mem_din},   {24'd0, d});
    chk("wr_busy",  {31'd0, req_ready}, 32'd0);
    tick();
`ifdef MEMCTRL_WRVERIFY_EN
    chk("vf1_cs",   {31'd0, mem_cs},    32'd1);
    chk("vf1_en",   {31'd0, mem_en},    32'd0);
    force_q0 = corrupt;
    tick();
    chk("vf2_cs",   {31'd0, mem_cs},    32'd1);
    chk("vf2_busy", {31'd0, req_ready}, 32'd0);
    tick();
    force_q0 = 1'b0;
`else
    if (corrupt) $display("note: corrupt ignored without write verify");
`endif
    chk("wr_done_cs",    {31'd0, mem_cs},    32'd0);
    chk("wr_done_en",    {31'd0, mem_en},    32'd0);
    chk("wr_done_ready", {31'd0, req_ready}, 32'd1);
    chk("wr_no_rsp",     {31'd0, rsp_valid}, 32'd0);
  endtask

  task automatic do_read(input logic [3:0] a, input logic [7:0] exp, input int stall);
    wait_ready();
    rsp_ready = (stall == 0);
    req_valid = 1'b1; req_wr = 1'b0; req_addr = a;
    tick();
    req_valid = 1'b0; req_addr = '0;
    chk("rd1_cs",   {31'd0, mem_cs},    32'd1);
    chk("rd1_en",   {31'd0, mem_en},    32'd0);
    chk("rd1_addr", {28'd0, mem_addr},  {28'd0, a});
    chk("rd1_busy", {31'd0, req_ready}, 32'd0);
    tick();
    chk("rd2_cs",   {31'd0, mem_cs},    32'd1);
    chk("rd2_rv",   {31'd0, rsp_valid}, 32'd0);
    tick();
    chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("rsp_data",  {24'd0, rsp_data},  {24'd0, exp});
    chk("rsp_cs",    {31'd0, mem_cs},    32'd0);
    chk("rsp_busy",  {31'd0, req_ready}, 32'd0);
    for (int i = 0; i < stall; i++) begin
      tick();
      chk("stall_valid", {31'd0, rsp_valid}, 32'd1);
      chk("stall_data",  {24'd0, rsp_data},  {24'd0, exp});
      chk("stall_busy",  {31'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    chk("rsp_done_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rsp_done_ready", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    // Reset held for 3 cycles
    rst_n = 1'b0;
    tick(); tick(); tick();
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_data",  {24'd0, rsp_data},  32'd0);
    chk("rst_wr_err",    {31'd0, wr_err},    32'd0);
    chk("rst_mem_cs",    {31'd0, mem_cs},    32'd0);
    chk("rst_mem_en",    {31'd0, mem_en},    32'd0);
    chk("rst_mem_addr",  {28'd0, mem_addr},  32'd0);
    chk("rst_mem_din",   {24'd0, mem_din},   32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_ready_pre", {31'd0, req_ready}, 32'd0);
    tick();
    chk("rel_ready_post", {31'd0, req_ready}, 32'd1);

    do_write(4'h3, 8'hA5, 1'b0);
    do_read(4'h3, 8'hA5, 0);

    for (int a = 0; a < 16; a++) begin
      logic [3:0] aa;
      aa = a[3:0];
      do_write(aa, {4'h0, aa} ^ 8'h5A, 1'b0);
    end
    for (int a = 0; a < 16; a++) begin
      logic [3:0] aa;
      aa = a[3:0];
      do_read(aa, {4'h0, aa} ^ 8'h5A, 0);
    end

    do_read(4'hA, 8'h50, 5);

    // Reset asserted while in RD2
    wait_ready();
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 4'h3;
    tick();
    req_valid = 1'b0;
    tick();
    chk("mid_rd2_cs", {31'd0, mem_cs}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cs",    {31'd0, mem_cs},    32'd0);
    chk("mid_rst_rv",    {31'd0, rsp_valid}, 32'd0);
    chk("mid_rst_ready", {31'd0, req_ready}, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    do_read(4'h5, 8'h5F, 0);

`ifdef MEMCTRL_WRVERIFY_EN
    do_write(4'h6, 8'h3C, 1'b0);
    chk("vf_clean_err", {31'd0, wr_err}, 32'd0);
    do_write(4'h7, 8'hFF, 1'b1);
    chk("vf_bad_err", {31'd0, wr_err}, 32'd1);
    do_write(4'h8, 8'h11, 1'b0);
    chk("vf_sticky_err", {31'd0, wr_err}, 32'd1);
`else
    chk("no_vf_err", {31'd0, wr_err}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
